mem_region_decoder: RTL and testbench
=====================================

MEM_REGION_DECODER -- requirements
Module: mem_region_decoder

Interface
REQ-001 The module SHALL have parameter NUM_REGIONS, default 2, giving the number of decoded address windows (1..8).
REQ-002 The module SHALL have parameter PADDR_W, default 13, giving the physical address width.
REQ-003 The module SHALL have parameter REGION_BASE, default {32'h7FFFEFFC, 32'h10010000}, giving the packed inclusive start addresses, region 0 in the LSBs.
REQ-004 The module SHALL have parameter REGION_END, default {32'h7FFFFFFC, 32'h10011000}, giving the packed exclusive end addresses.
REQ-005 The module SHALL have parameter REGION_PBASE, default {13'h1000, 13'h0000}, giving the packed physical base for each region.
REQ-006 The module SHALL have these ports (name, direction, width, meaning): clk in 1 clock; rst in 1 reset; clock is one clock; reset is synchronous and active-high.
REQ-007 The module SHALL have request ports: req_valid in 1; req_ready out 1; req_vaddr in 32; req_size in 2 (0 byte, 1 half, 2 word, 3 reserved).
REQ-008 The module SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_paddr out PADDR_W; rsp_region out 3; rsp_fault out 1; rsp_cause out 2 (0 none, 1 unmapped, 2 misaligned, 3 straddle/reserved-size).
REQ-009 The module SHALL have fault-status ports: fault_sticky out 1; bad_vaddr out 32; fault_count out 8; fault_clr in 1.

Function
REQ-010 The module SHALL register one pipeline stage; a request accepted in cycle N SHALL appear on rsp_* in cycle N+1.
REQ-011 req_ready SHALL equal (!rsp_valid || rsp_ready); a request SHALL be accepted when req_valid && req_ready.
REQ-012 rsp_* SHALL hold stable while rsp_valid && !rsp_ready.
REQ-013 When a response is consumed and no new request is accepted in the same cycle, rsp_valid SHALL clear.
REQ-014 A region SHALL hit when REGION_BASE[i] <= vaddr < REGION_END[i], using unsigned 32-bit compares.
REQ-015 When several regions hit, the lowest index SHALL win.
REQ-016 On a hit, rsp_paddr SHALL be the low PADDR_W bits of ((vaddr - REGION_BASE[i]) + REGION_PBASE[i]), and rsp_region SHALL be i.
REQ-017 On no hit, the response SHALL be rsp_fault=1, rsp_cause=1, rsp_paddr=0, rsp_region=0.
REQ-018 The response SHALL be a straddle fault (cause 3, paddr 0) when vaddr hits a region but vaddr+bytes-1 >= REGION_END[i].
REQ-019 req_size=3 SHALL also produce cause 3.
REQ-020 Fault priority SHALL be unmapped > misaligned > straddle.
REQ-021 On the first faulting accepted request while fault_sticky=0, the module SHALL set fault_sticky and capture bad_vaddr.
REQ-022 Later faults SHALL NOT overwrite bad_vaddr while fault_sticky=1.
REQ-023 fault_clr SHALL clear fault_sticky in the next cycle.
REQ-024 When fault_clr coincides with a new fault, the new fault SHALL win: sticky stays set and bad_vaddr takes the new address.
REQ-025 fault_count SHALL increment once per faulting accepted request and SHALL saturate at 255; it is not cleared by fault_clr.

Reset
REQ-026 When rst is high at a clk edge, the module SHALL set rsp_valid=0, rsp_paddr=0, rsp_region=0, rsp_fault=0, rsp_cause=0, fault_sticky=0, bad_vaddr=0 and fault_count=0.
REQ-027 An in-flight response SHALL be discarded by reset.
REQ-028 req_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-029 With MEMDEC_ALIGN_CHECK_EN defined, a half request with vaddr[0]=1 or a word request with vaddr[1:0]!=0 SHALL fault with cause 2.
REQ-030 Without MEMDEC_ALIGN_CHECK_EN, the module SHALL skip the alignment check, and cause 2 SHALL never be produced.

Structure
REQ-031 The shared package memdec_pkg SHALL hold the size encodings, the cause encodings and the default region base/end/pbase constants.
REQ-032 The per-region compare and offset logic SHALL be the sub-module memdec_region_match, instantiated NUM_REGIONS times via generate.

Verification
REQ-033 Bench: word request at 0x10010010 -> next cycle rsp_region=0, rsp_paddr=0x0010, rsp_fault=0.
REQ-034 Bench: word request at 0x7FFFF000 -> rsp_region=1, rsp_paddr=0x1004, rsp_fault=0.
REQ-035 Bench: word request at 0x00400000, then at 0x00000004 -> both cause 1; bad_vaddr=0x00400000; fault_count=2.
REQ-036 Bench: with MEMDEC_ALIGN_CHECK_EN defined, word request at 0x10010002 -> cause 2; without the macro, the same request gives rsp_paddr=0x0002, no fault; without the macro, word request at 0x10010FFE -> cause 3.
REQ-037 Bench: hold rsp_ready=0 for 3 cycles with req_valid high -> req_ready=0 and rsp_* unchanged; release -> a back-to-back stream proceeds at 1 per cycle.
REQ-038 Bench: assert fault_clr in the same cycle a fault at 0x00000008 is accepted -> fault_sticky stays 1 and bad_vaddr=0x00000008; assert rst mid-stream -> all outputs zero next cycle.

Source files
------------

// File: rtl/memdec_pkg.sv
// Shared definitions for the memory region decoder.
// Holds the access-size and fault-cause encodings, common widths,
// the default region map and a helper giving the last-byte offset of an access.
package memdec_pkg;

  localparam int unsigned VADDR_W  = 32;
  localparam int unsigned REGION_W = 3;
  localparam int unsigned COUNT_W  = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_UNMAPPED = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_STRADDLE = 2'd3
  } cause_e;

  // Default two-region map, region 0 in the LSBs
  localparam logic [63:0] DEF_REGION_BASE  = {32'h7FFFEFFC, 32'h10010000};
  localparam logic [63:0] DEF_REGION_END   = {32'h7FFFFFFC, 32'h10011000};
  localparam logic [25:0] DEF_REGION_PBASE = {13'h1000, 13'h0000};

  // Offset of the last byte touched by an access (bytes - 1)
  function automatic logic [1:0] last_offset(input logic [1:0] size);
    case (size)
      SIZE_HALF: last_offset = 2'd1;
      SIZE_WORD: last_offset = 2'd3;
      default:   last_offset = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/memdec_region_match.sv
// Per-region address window compare and physical offset computation.
// Ports:
//   vaddr      in  32       virtual address of the request
//   last_off   in  2        offset of the last byte of the access (bytes - 1)
//   hit_c      out 1        BASE <= vaddr < END_ADDR (unsigned)
//   straddle_c out 1        last byte of the access reaches END_ADDR or beyond
//   paddr_c    out PADDR_W  low bits of (vaddr - BASE) + PBASE
module memdec_region_match
  import memdec_pkg::*;
#(
  parameter int unsigned         PADDR_W  = 13,
  parameter logic [VADDR_W-1:0]  BASE     = 32'h10010000,
  parameter logic [VADDR_W-1:0]  END_ADDR = 32'h10011000,
  parameter logic [PADDR_W-1:0]  PBASE    = '0
) (
  input  logic [VADDR_W-1:0] vaddr,
  input  logic [1:0]         last_off,
  output logic               hit_c,
  output logic               straddle_c,
  output logic [PADDR_W-1:0] paddr_c
);

  logic [VADDR_W:0] last_byte;

  assign hit_c = (vaddr >= BASE) && (vaddr < END_ADDR);

  // One extra bit so an access near 0xFFFFFFFF cannot wrap below END_ADDR
  assign last_byte  = {1'b0, vaddr} + (VADDR_W+1)'(last_off);
  assign straddle_c = last_byte >= {1'b0, END_ADDR};

  // Only the low PADDR_W bits survive, so the add can be done at that width
  assign paddr_c = PADDR_W'(vaddr - BASE) + PBASE;

endmodule

// File: rtl/mem_region_decoder.sv
// Memory region decoder: translates a virtual address into a physical
// address through a set of windows, one registered pipeline stage with
// valid/ready handshake, and fault status (sticky flag, first bad address,
// saturating fault counter).
// Optional feature macro: MEMDEC_ALIGN_CHECK_EN enables the half/word
// alignment check (cause 2); without it that check is skipped.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_vaddr[31:0], req_size[1:0] request address and size
//   rsp_valid/rsp_ready           response handshake
//   rsp_paddr, rsp_region[2:0]    translated address and matching region
//   rsp_fault, rsp_cause[1:0]     fault flag and cause
//   fault_sticky, bad_vaddr[31:0] first-fault flag and captured address
//   fault_count[7:0]              saturating fault counter
//   fault_clr                     clears fault_sticky
module mem_region_decoder
  import memdec_pkg::*;
#(
  parameter int unsigned                       NUM_REGIONS  = 2,
  parameter int unsigned                       PADDR_W      = 13,
  parameter logic [NUM_REGIONS*VADDR_W-1:0]    REGION_BASE  = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*VADDR_W-1:0]    REGION_END   = DEF_REGION_END,
  parameter logic [NUM_REGIONS*PADDR_W-1:0]    REGION_PBASE = DEF_REGION_PBASE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [VADDR_W-1:0]  req_vaddr,
  input  logic [1:0]          req_size,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PADDR_W-1:0]  rsp_paddr,
  output logic [REGION_W-1:0] rsp_region,
  output logic                rsp_fault,
  output logic [1:0]          rsp_cause,
  output logic                fault_sticky,
  output logic [VADDR_W-1:0]  bad_vaddr,
  output logic [COUNT_W-1:0]  fault_count,
  input  logic                fault_clr
);

  logic                 accept;
  logic [1:0]           last_off;
  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] straddle;
  logic [PADDR_W-1:0]   region_paddr [NUM_REGIONS];

  logic                 sel_hit;
  logic                 sel_straddle;
  logic [REGION_W-1:0]  sel_idx;
  logic [PADDR_W-1:0]   sel_paddr;
  logic                 misaligned;

  logic                 nxt_fault;
  logic [1:0]           nxt_cause;
  logic [PADDR_W-1:0]   nxt_paddr;
  logic [REGION_W-1:0]  nxt_region;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign last_off  = last_offset(req_size);

  // One window comparator per region
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    memdec_region_match #(
      .PADDR_W  (PADDR_W),
      .BASE     (REGION_BASE[g*VADDR_W +: VADDR_W]),
      .END_ADDR (REGION_END[g*VADDR_W +: VADDR_W]),
      .PBASE    (REGION_PBASE[g*PADDR_W +: PADDR_W])
    ) u_match (
      .vaddr      (req_vaddr),
      .last_off   (last_off),
      .hit_c      (hit[g]),
      .straddle_c (straddle[g]),
      .paddr_c    (region_paddr[g])
    );
  end

  // Priority select: scanning downward lets the lowest hitting index win
  always_comb begin
    sel_hit      = 1'b0;
    sel_straddle = 1'b0;
    sel_idx      = '0;
    sel_paddr    = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_hit      = 1'b1;
        sel_straddle = straddle[i];
        sel_idx      = REGION_W'(i);
        sel_paddr    = region_paddr[i];
      end
    end
  end

`ifdef MEMDEC_ALIGN_CHECK_EN
  assign misaligned = ((req_size == SIZE_HALF) && req_vaddr[0]) ||
                      ((req_size == SIZE_WORD) && (req_vaddr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Response formation with fault priority unmapped > misaligned > straddle
  always_comb begin
    nxt_fault  = 1'b0;
    nxt_cause  = CAUSE_NONE;
    nxt_paddr  = '0;
    nxt_region = '0;
    if (!sel_hit) begin
      nxt_fault = 1'b1;
      nxt_cause = CAUSE_UNMAPPED;
    end else if (misaligned) begin
      nxt_fault  = 1'b1;
      nxt_cause  = CAUSE_MISALIGN;
      nxt_region = sel_idx;
    end else if ((req_size == SIZE_RSVD) || sel_straddle) begin
      nxt_fault  = 1'b1;
      nxt_cause  = CAUSE_STRADDLE;
      nxt_region = sel_idx;
    end else begin
      nxt_paddr  = sel_paddr;
      nxt_region = sel_idx;
    end
  end

  // Response register and fault status
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_paddr    <= '0;
      rsp_region   <= '0;
      rsp_fault    <= 1'b0;
      rsp_cause    <= '0;
      fault_sticky <= 1'b0;
      bad_vaddr    <= '0;
      fault_count  <= '0;
    end else begin
      if (accept) begin
        rsp_valid  <= 1'b1;
        rsp_paddr  <= nxt_paddr;
        rsp_region <= nxt_region;
        rsp_fault  <= nxt_fault;
        rsp_cause  <= nxt_cause;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      // A new fault beats a coincident clear and recaptures the address
      if (accept && nxt_fault) begin
        if (!fault_sticky || fault_clr) begin
          fault_sticky <= 1'b1;
          bad_vaddr    <= req_vaddr;
        end
        if (fault_count != {COUNT_W{1'b1}}) begin
          fault_count <= fault_count + COUNT_W'(1);
        end
      end else if (fault_clr) begin
        fault_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_region_decoder.sv
// Directed self-checking bench for mem_region_decoder (default region map).
module tb_mem_region_decoder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [12:0] rsp_paddr;
  logic [2:0]  rsp_region;
  logic        rsp_fault;
  logic [1:0]  rsp_cause;
  logic        fault_sticky;
  logic [31:0] bad_vaddr;
  logic [7:0]  fault_count;
  logic        fault_clr;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  mem_region_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_vaddr    (req_vaddr),
    .req_size     (req_size),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_paddr    (rsp_paddr),
    .rsp_region   (rsp_region),
    .rsp_fault    (rsp_fault),
    .rsp_cause    (rsp_cause),
    .fault_sticky (fault_sticky),
    .bad_vaddr    (bad_vaddr),
    .fault_count  (fault_count),
    .fault_clr    (fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one request for one cycle; returns at the following negedge
  task automatic issue(input logic [31:0] addr, input logic [1:0] size);
    @(negedge clk);
    req_valid = 1'b1;
    req_vaddr = addr;
    req_size  = size;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic fault, input logic [1:0] cause,
                           input logic [12:0] paddr);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_fault"}, 32'(rsp_fault), 32'(fault));
    check({tag, "_cause"}, 32'(rsp_cause), 32'(cause));
    check({tag, "_paddr"}, 32'(rsp_paddr), 32'(paddr));
    if (fault && exp_cnt < 255) exp_cnt++;
    check({tag, "_count"}, 32'(fault_count), 32'(exp_cnt));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_vaddr = '0;
    req_size  = 2'd0;
    rsp_ready = 1'b1;
    fault_clr = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_sticky", 32'(fault_sticky), 32'd0);
    check("rst_bad", bad_vaddr, 32'd0);
    check("rst_count", 32'(fault_count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    // Basic hits in both regions
    issue(32'h10010010, 2'd2);
    check_rsp("hit0", 1'b0, 2'd0, 13'h0010);
    check("hit0_region", 32'(rsp_region), 32'd0);
    issue(32'h7FFFF000, 2'd2);
    check_rsp("hit1", 1'b0, 2'd0, 13'h1004);
    check("hit1_region", 32'(rsp_region), 32'd1);

    // Unmapped faults; first address is captured
    issue(32'h00400000, 2'd2);
    check_rsp("unmap_a", 1'b1, 2'd1, 13'h0);
    check("unmap_a_region", 32'(rsp_region), 32'd0);
    check("unmap_a_sticky", 32'(fault_sticky), 32'd1);
    check("unmap_a_bad", bad_vaddr, 32'h00400000);
    issue(32'h00000004, 2'd2);
    check_rsp("unmap_b", 1'b1, 2'd1, 13'h0);
    check("unmap_b_bad", bad_vaddr, 32'h00400000);
    check("unmap_b_count", 32'(fault_count), 32'd2);

    // Alignment and straddle cases
`ifdef MEMDEC_ALIGN_CHECK_EN
    issue(32'h10010002, 2'd2);
    check_rsp("mis_word", 1'b1, 2'd2, 13'h0);
    issue(32'h10010FFE, 2'd2);
    check_rsp("mis_word_end", 1'b1, 2'd2, 13'h0);
    issue(32'h10010FFF, 2'd1);
    check_rsp("mis_half_end", 1'b1, 2'd2, 13'h0);
`else
    issue(32'h10010002, 2'd2);
    check_rsp("unal_word", 1'b0, 2'd0, 13'h0002);
    issue(32'h10010FFE, 2'd2);
    check_rsp("strad_word", 1'b1, 2'd3, 13'h0);
    issue(32'h10010FFF, 2'd1);
    check_rsp("strad_half", 1'b1, 2'd3, 13'h0);
`endif
    issue(32'h10010FFC, 2'd2);
    check_rsp("last_word0", 1'b0, 2'd0, 13'h0FFC);
    issue(32'h10010FFF, 2'd0);
    check_rsp("last_byte0", 1'b0, 2'd0, 13'h0FFF);
    issue(32'h10011000, 2'd0);
    check_rsp("end0_excl", 1'b1, 2'd1, 13'h0);
    issue(32'h10010000, 2'd3);
    check_rsp("rsvd_size", 1'b1, 2'd3, 13'h0);
    issue(32'h7FFFEFFC, 2'd0);
    check_rsp("base1", 1'b0, 2'd0, 13'h1000);
    check("base1_region", 32'(rsp_region), 32'd1);
    issue(32'h7FFFFFF8, 2'd2);
    check_rsp("last_word1", 1'b0, 2'd0, 13'h1FFC);
    issue(32'h7FFFFFFC, 2'd2);
    check_rsp("end1_excl", 1'b1, 2'd1, 13'h0);
    check("sticky_keep_bad", bad_vaddr, 32'h00400000);

    // Backpressure: drain, then stall with a pending request
    @(negedge clk);
    check("drain_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_vaddr = 32'h10010020;
    req_size  = 2'd2;
    @(negedge clk);
    req_vaddr = 32'h10010030;
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_paddr", 32'(rsp_paddr), 32'h0020);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stream_paddr", 32'(rsp_paddr), 32'h0030 + 32'(i) * 32'h10);
      check("stream_valid", 32'(rsp_valid), 32'd1);
      req_vaddr = 32'h10010040 + 32'(i) * 32'h10;
    end
    req_valid = 1'b0;
    @(negedge clk);

    // fault_clr coincident with a new fault: the fault wins
    req_valid = 1'b1;
    req_vaddr = 32'h00000008;
    req_size  = 2'd2;
    fault_clr = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    fault_clr = 1'b0;
    check_rsp("clr_fault", 1'b1, 2'd1, 13'h0);
    check("clr_fault_sticky", 32'(fault_sticky), 32'd1);
    check("clr_fault_bad", bad_vaddr, 32'h00000008);

    // Plain clear drops the sticky flag but not the count
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_sticky", 32'(fault_sticky), 32'd0);
    check("clr_count_kept", 32'(fault_count), 32'(exp_cnt));

    // Counter saturation with a stream of unmapped requests
    req_valid = 1'b1;
    req_vaddr = 32'h00000000;
    req_size  = 2'd0;
    repeat (260) @(negedge clk);
    req_valid = 1'b0;
    check("sat_count", 32'(fault_count), 32'd255);
    check("sat_bad", bad_vaddr, 32'h00000000);
    check("sat_sticky", 32'(fault_sticky), 32'd1);

    // Reset mid-stream discards the in-flight response
    req_valid = 1'b1;
    req_vaddr = 32'h10010010;
    req_size  = 2'd2;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_valid", 32'(rsp_valid), 32'd0);
    check("mrst_paddr", 32'(rsp_paddr), 32'd0);
    check("mrst_region", 32'(rsp_region), 32'd0);
    check("mrst_fault", 32'(rsp_fault), 32'd0);
    check("mrst_cause", 32'(rsp_cause), 32'd0);
    check("mrst_sticky", 32'(fault_sticky), 32'd0);
    check("mrst_bad", bad_vaddr, 32'd0);
    check("mrst_count", 32'(fault_count), 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
